// File: rtl/bu2020_memory_responder.sv
// rtl/bu2020_memory_responder.sv - BU2020 instruction/data memory responder with word-stream loader
//
// Purpose: holds a DEPTH x DATA_W instruction memory and a DEPTH x DATA_W data
// memory. It serves the core's instruction fetch port and its bidirectional data
// port. A word-stream loader fills either memory and stalls the core while it runs.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   Memory_addressbus       data-memory word address from the core
//   Memory_databus          bidirectional data bus, driven here only on core reads
//   Memory_writemode        1 = core writes data memory, 0 = core reads it
//   Instruction_addressbus  instruction fetch address
//   Instruction_databus     fetched instruction word (0 while not idle or in reset)
//   load_start/sel/len      load request, target memory (0 = imem, 1 = dmem), word count
//   load_valid/data/ready   load word stream handshake
//   load_done               one-cycle pulse when a load completes
//   cpu_hold                core stall request
module bu2020_memory_responder #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Memory_addressbus,
    inout  wire  [DATA_W-1:0] Memory_databus,
    input  logic              Memory_writemode,
    input  logic [ADDR_W-1:0] Instruction_addressbus,
    output logic [DATA_W-1:0] Instruction_databus,
    input  logic              load_start,
    input  logic              load_sel,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              cpu_hold
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              sel_q, sel_d;

    logic [DATA_W-1:0] imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    logic idle_live;
    logic load_wr;

    // The core only sees the memories while the responder is idle and out of reset.
    assign idle_live = rst_n && (state_q == S_IDLE);
    assign load_wr   = rst_n && (state_q == S_LOAD) && load_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    sel_d   = load_sel;
                    len_d   = load_len;
                    cnt_d   = '0;
                    state_d = (load_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    // Last word: hold cnt so it never exceeds len-1.
                    if (cnt_q == len_q - ADDR_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
        end
    end

    // Memory contents survive reset; only the loader and idle core writes update them.
    always_ff @(posedge clk) begin
        if (load_wr && !sel_q) begin
            imem[cnt_q] <= load_data;
        end
        if (load_wr && sel_q) begin
            dmem[cnt_q] <= load_data;
        end else if (idle_live && Memory_writemode) begin
            dmem[Memory_addressbus] <= Memory_databus;
        end
    end

    assign cpu_hold            = ~rst_n | (state_q != S_IDLE);
    assign load_ready          = rst_n & (state_q == S_LOAD);
    assign load_done           = rst_n & (state_q == S_DONE);
    assign Instruction_databus = idle_live ? imem[Instruction_addressbus] : '0;
    assign Memory_databus      = (idle_live && !Memory_writemode) ? dmem[Memory_addressbus] : 'z;

endmodule

// File: doc/bu2020_memory_responder.md
# bu2020_memory_responder

Memory-side responder for the BU2020 core's two memory ports. It holds a 4096×16 instruction memory and a 4096×16 data memory. It serves the core's instruction fetch port and its bidirectional data port. A word-stream loader fills either memory and holds the core off while loading.

## Interface
Parameters:
- ADDR_W, 12, address width of both core-facing ports.
- DATA_W, 16, word width.
- DEPTH, 4096, words per memory; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
- Memory_addressbus  input  ADDR_W  data-memory word address from the core.
- Memory_databus  inout  DATA_W  bidirectional data bus; responder drives it only on reads.
- Memory_writemode  input  1  1 = core writes data memory, 0 = core reads it.
- Instruction_addressbus  input  ADDR_W  instruction fetch address.
- Instruction_databus  output  DATA_W  fetched instruction word.
- load_start  input  1  one-cycle request to begin a load.
- load_sel  input  1  target memory, sampled with load_start: 0 = instruction, 1 = data.
- load_len  input  ADDR_W  number of words to load, sampled with load_start; 0 = no-op load.
- load_valid  input  1  a load word is present on load_data.
- load_data  input  DATA_W  load word.
- load_ready  output  1  responder accepts a load word this cycle.
- load_done  output  1  one-cycle pulse when a load completes.
- cpu_hold  output  1  core must stall while this signal is high.

## Operation
- FSM states: IDLE, LOAD, DONE. The reset state is IDLE.
- IDLE:
  - A posedge with load_start=1 latches load_sel and load_len and clears the word counter cnt to 0.
  - If load_len=0, the FSM goes to DONE. Otherwise it goes to LOAD.
  - load_start is ignored in LOAD and DONE.
- LOAD:
  - load_ready=1.
  - At each posedge with load_valid=1, load_data is written to the selected memory at address cnt, and cnt increments.
  - When the accepted word is number load_len (cnt = load_len−1 before the increment), the FSM goes to DONE.
  - load_valid=0 stalls the load indefinitely. No timeout.
- DONE: lasts exactly one cycle with load_done=1, then the FSM returns to IDLE.
- Outputs as a decode of state/reset:
  - cpu_hold = ~rst_n | (state≠IDLE).
  - load_ready = rst_n & (state==LOAD).
  - load_done = rst_n & (state==DONE).
- Instruction port:
  - Instruction_databus = imem[Instruction_addressbus] (combinational) when state==IDLE.
  - It is 16'h0000 in LOAD, in DONE, and while rst_n=0.
- Data port, read:
  - When rst_n=1, state==IDLE and Memory_writemode=0, the responder drives Memory_databus with dmem[Memory_addressbus] (combinational).
  - In every other case it drives 'z'.
- Data port, write:
  - At a posedge with rst_n=1, state==IDLE and Memory_writemode=1, Memory_databus is written to dmem[Memory_addressbus].
  - Core writes in LOAD or DONE are dropped.
- Reset behaviour:
  - Reset does not clear memory arrays; unloaded locations read X in simulation.
  - Reset mid-load returns the FSM to IDLE. Words already written stay written, and load_done does not pulse.
- Address and counter widths:
  - Addresses are exactly ADDR_W bits. There is no wrap or out-of-range case.
  - cnt is ADDR_W bits and never exceeds load_len−1.

## Timing
- Reset values (rst_n=0, and first cycle after): state IDLE, cnt 0, load_ready 0, load_done 0, cpu_hold 1, Instruction_databus 0, Memory_databus 'z'.
- Read latency:
  - Instruction and data reads are zero-cycle combinational.
  - A read in the cycle after a write to the same address returns the new value.
  - A same-cycle read/write on the data port is impossible, because writemode selects one.
- Write latency: writes commit on the posedge; they are visible to combinational reads right after that edge.
- Load handshake: a word transfers on a posedge where load_valid & load_ready are both 1. One word per cycle is the maximum rate.
- Load duration: load_start edge → first load_ready high is 1 cycle. An N-word load at full rate takes N cycles in LOAD plus 1 in DONE.
- Hold window: cpu_hold rises in the cycle after the load_start edge. It falls in the cycle after DONE.
- A load with load_len=0 goes IDLE→DONE→IDLE. cpu_hold is high for 1 cycle and there are no writes.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with load_start=1 → cpu_hold=1, load_ready=0, Instruction_databus=0, Memory_databus='z', and state IDLE after release.
- Instruction load of 4 words:
  - Stimulus: load_sel=0, load_len=4, data 16'h1111, 16'h2222, 16'h3333, 16'h4444 with valid every cycle.
  - Required: load_done pulses exactly 5 cycles after the start edge. Afterwards, Instruction_addressbus=2 reads 16'h3333.
- Throttled data load:
  - Stimulus: load_sel=1, load_len=3, load_valid toggling 1,0,1,0,1.
  - Required: exactly 3 writes to dmem[0..2] and cpu_hold high throughout.
  - Afterwards, a core read of address 1 drives the second word on Memory_databus.
- Core data path:
  - Stimulus: write 16'hBEEF to address 12'hFFF, then read address 12'hFFF the next cycle.
  - Required: the bus shows 16'hBEEF while writemode=0, and the responder drives 'z' while writemode=1.
- Boundaries:
  - load_len=0 → a single-cycle load_done pulse and memory unchanged.
  - Core write during LOAD → dmem unchanged.
  - Second load_start during LOAD → ignored.
- Reset mid-load: with load_len=8, assert rst_n=0 after 3 words → IDLE and no load_done pulse. Words 0–2 are written, and word 3 is untouched.
